// File: rtl/hazard_pkg.sv
// Shared types and comparison helpers for the hazard scoreboard.
// Entry fields are sized for the widest supported configuration; narrower instances zero-extend.
package hazard_pkg;

    localparam int HZ_ADDR_MAX = 8;
    localparam int HZ_TNEW_MAX = 4;

    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_W  = 2'd1;
    localparam logic [1:0] FWD_M  = 2'd2;
    localparam logic [1:0] FWD_E  = 2'd3;

    typedef struct packed {
        logic                   valid;
        logic [HZ_ADDR_MAX-1:0] a3;
        logic [HZ_TNEW_MAX-1:0] tnew;
        logic [HZ_ADDR_MAX-1:0] rs;
        logic [HZ_ADDR_MAX-1:0] rt;
    } hz_entry_t;

    // A Tuse of all-ones (at the instance's TNEW_W) marks an operand that is never read.
    function automatic logic tuse_unused(input logic [HZ_TNEW_MAX-1:0] tuse, input int w);
        return tuse == HZ_TNEW_MAX'((1 << w) - 1);
    endfunction

    // The single producer/consumer comparison; register 0 never matches.
    function automatic logic hz_match(input hz_entry_t e, input logic [HZ_ADDR_MAX-1:0] src);
        return e.valid && (e.a3 == src) && (src != '0);
    endfunction

    function automatic logic hz_ready(input hz_entry_t e, input logic [HZ_ADDR_MAX-1:0] src);
        return hz_match(e, src) && (e.tnew == '0);
    endfunction

    function automatic logic hz_pending(input hz_entry_t e, input logic [HZ_ADDR_MAX-1:0] src,
                                        input logic [HZ_TNEW_MAX-1:0] tuse);
        return hz_match(e, src) && (e.tnew > tuse);
    endfunction

    function automatic logic [HZ_TNEW_MAX-1:0] tnew_dec(input logic [HZ_TNEW_MAX-1:0] t);
        return (t == '0) ? '0 : t - 1'b1;
    endfunction

endpackage

// File: rtl/md_busy_counter.sv
// Mult/div busy countdown; a new start always reloads, so the latest operation wins.
module md_busy_counter #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic start_i,
    input  logic is_div_i,
    output logic busy_o
);
    localparam int MAXC  = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W = $clog2(MAXC + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (start_i)
            cnt_d = is_div_i ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        else if (cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// E/M/W register-write scoreboard: raises load-use / mult-div stalls and picks forwarding sources.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int ADDR_W      = 5,
    parameter int TNEW_W      = 2,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] D_Rs,
    input  logic [ADDR_W-1:0] D_Rt,
    input  logic [TNEW_W-1:0] D_Tuse_Rs,
    input  logic [TNEW_W-1:0] D_Tuse_Rt,
    input  logic [ADDR_W-1:0] D_A3,
    input  logic              D_RegWrite,
    input  logic [TNEW_W-1:0] D_Tnew,
    input  logic              D_MdUse,
    input  logic              E_MdStart,
    input  logic              E_MdIsDiv,
    input  logic              flush,
    output logic              stall,
    output logic [1:0]        D_FwdRs_Sel,
    output logic [1:0]        D_FwdRt_Sel,
    output logic [1:0]        E_FwdRs_Sel,
    output logic [1:0]        E_FwdRt_Sel,
    output logic              M_FwdRt_Sel,
    output logic              md_busy
);
    hz_entry_t e_q, m_q, w_q;
    hz_entry_t e_d, m_d, w_d;

    logic [HZ_ADDR_MAX-1:0] d_rs, d_rt, d_a3;
    logic [HZ_TNEW_MAX-1:0] tuse_rs, tuse_rt, d_tnew;
    logic                   hz_stall, md_stall, cnt_busy;

    assign d_rs    = HZ_ADDR_MAX'(D_Rs);
    assign d_rt    = HZ_ADDR_MAX'(D_Rt);
    assign d_a3    = HZ_ADDR_MAX'(D_A3);
    assign tuse_rs = HZ_TNEW_MAX'(D_Tuse_Rs);
    assign tuse_rt = HZ_TNEW_MAX'(D_Tuse_Rt);
    assign d_tnew  = HZ_TNEW_MAX'(D_Tnew);

    md_busy_counter #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_md (
        .clk     (clk),
        .reset   (reset),
        .start_i (E_MdStart),
        .is_div_i(E_MdIsDiv),
        .busy_o  (cnt_busy)
    );

    // Outputs are masked while reset is asserted so state still settling cannot leak out.
    assign md_busy  = cnt_busy && !reset;
    assign md_stall = D_MdUse && (md_busy || E_MdStart);
    assign hz_stall = !reset && (
        (!tuse_unused(tuse_rs, TNEW_W) &&
            (hz_pending(e_q, d_rs, tuse_rs) || hz_pending(m_q, d_rs, tuse_rs))) ||
        (!tuse_unused(tuse_rt, TNEW_W) &&
            (hz_pending(e_q, d_rt, tuse_rt) || hz_pending(m_q, d_rt, tuse_rt))));
    assign stall = hz_stall || md_stall;

    always_comb begin
        D_FwdRs_Sel = FWD_RF;
        D_FwdRt_Sel = FWD_RF;
        E_FwdRs_Sel = FWD_RF;
        E_FwdRt_Sel = FWD_RF;
        M_FwdRt_Sel = 1'b0;
        if (!reset) begin
            D_FwdRs_Sel = hz_ready(e_q, d_rs) ? FWD_E : hz_ready(m_q, d_rs) ? FWD_M :
                          hz_ready(w_q, d_rs) ? FWD_W : FWD_RF;
            D_FwdRt_Sel = hz_ready(e_q, d_rt) ? FWD_E : hz_ready(m_q, d_rt) ? FWD_M :
                          hz_ready(w_q, d_rt) ? FWD_W : FWD_RF;
            E_FwdRs_Sel = hz_ready(m_q, e_q.rs) ? FWD_M : hz_ready(w_q, e_q.rs) ? FWD_W : FWD_RF;
            E_FwdRt_Sel = hz_ready(m_q, e_q.rt) ? FWD_M : hz_ready(w_q, e_q.rt) ? FWD_W : FWD_RF;
            M_FwdRt_Sel = hz_ready(w_q, m_q.rt);
        end
    end

    // Tnew is counted from E entry, so it is loaded as-is and only ages on E->M and M->W.
    always_comb begin
        e_d = '0;
        if (!(stall || flush)) begin
            e_d.valid = D_RegWrite && (d_a3 != '0);
            e_d.a3    = d_a3;
            e_d.tnew  = d_tnew;
            e_d.rs    = d_rs;
            e_d.rt    = d_rt;
        end
        m_d      = e_q;
        m_d.tnew = tnew_dec(e_q.tnew);
        w_d      = m_q;
        w_d.tnew = tnew_dec(m_q.tnew);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            e_q <= e_d;
            m_q <= m_d;
            w_q <= w_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: each task walks one pipeline scenario cycle by cycle.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] D_Rs, D_Rt, D_A3;
    logic [1:0] D_Tuse_Rs, D_Tuse_Rt, D_Tnew;
    logic       D_RegWrite, D_MdUse, E_MdStart, E_MdIsDiv, flush;
    logic       stall, M_FwdRt_Sel, md_busy;
    logic [1:0] D_FwdRs_Sel, D_FwdRt_Sel, E_FwdRs_Sel, E_FwdRt_Sel;

    int n_tests = 0;
    int n_fail  = 0;

    hazard_scoreboard #(.ADDR_W(5), .TNEW_W(2), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset),
        .D_Rs(D_Rs), .D_Rt(D_Rt), .D_Tuse_Rs(D_Tuse_Rs), .D_Tuse_Rt(D_Tuse_Rt),
        .D_A3(D_A3), .D_RegWrite(D_RegWrite), .D_Tnew(D_Tnew), .D_MdUse(D_MdUse),
        .E_MdStart(E_MdStart), .E_MdIsDiv(E_MdIsDiv), .flush(flush),
        .stall(stall), .D_FwdRs_Sel(D_FwdRs_Sel), .D_FwdRt_Sel(D_FwdRt_Sel),
        .E_FwdRs_Sel(E_FwdRs_Sel), .E_FwdRt_Sel(E_FwdRt_Sel),
        .M_FwdRt_Sel(M_FwdRt_Sel), .md_busy(md_busy)
    );

    always #5 clk = ~clk;

    task automatic set_d(input logic [4:0] rs, input logic [4:0] rt, input logic [1:0] urs,
                         input logic [1:0] urt, input logic [4:0] a3, input logic we,
                         input logic [1:0] tnew);
        D_Rs = rs; D_Rt = rt; D_Tuse_Rs = urs; D_Tuse_Rt = urt;
        D_A3 = a3; D_RegWrite = we; D_Tnew = tnew;
    endtask

    task automatic idle();
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 1'b0, 2'd0);
        D_MdUse = 1'b0; E_MdStart = 1'b0; E_MdIsDiv = 1'b0; flush = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic drain();
        idle();
        repeat (4) tick();
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({stall, D_FwdRs_Sel, D_FwdRt_Sel, E_FwdRs_Sel, E_FwdRt_Sel, M_FwdRt_Sel, md_busy} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got stall=%b sels=%h/%h/%h/%h/%b busy=%b, want all 0",
                     stall, D_FwdRs_Sel, D_FwdRt_Sel, E_FwdRs_Sel, E_FwdRt_Sel, M_FwdRt_Sel, md_busy);
        end
        D_MdUse = 1'b1; E_MdStart = 1'b1;
        #1;
        n_tests++;
        if (stall !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_md_stall: got stall=%b, want 1", stall);
        end
        tick();
        idle();
        tick();
        reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({stall, D_FwdRs_Sel, D_FwdRt_Sel, E_FwdRs_Sel, E_FwdRt_Sel, M_FwdRt_Sel, md_busy} !== 11'd0) begin
            n_fail++;
            $display("FAIL post_reset_outputs: got stall=%b busy=%b, want 0/0", stall, md_busy);
        end
        tick();
    endtask

    // lw $1 (Tnew 2) then add reading $1 at Tuse 1
    task automatic test_load_use();
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd1, 1'b1, 2'd2);
        tick();
        set_d(5'd1, 5'd2, 2'd1, 2'd1, 5'd4, 1'b1, 2'd1);
        @(negedge clk);
        n_tests++;
        if (stall !== 1'b1) begin
            n_fail++;
            $display("FAIL load_use_stall_c0: got %b, want 1", stall);
        end
        tick();
        @(negedge clk);
        n_tests++;
        if (stall !== 1'b0 || D_FwdRs_Sel !== 2'd0) begin
            n_fail++;
            $display("FAIL load_use_stall_c1: got stall=%b dsel=%0d, want 0/0", stall, D_FwdRs_Sel);
        end
        tick();
        idle();
        @(negedge clk);
        n_tests++;
        if (E_FwdRs_Sel !== 2'd1 || E_FwdRt_Sel !== 2'd0) begin
            n_fail++;
            $display("FAIL load_use_e_fwd: got rs=%0d rt=%0d, want 1/0", E_FwdRs_Sel, E_FwdRt_Sel);
        end
        drain();
    endtask

    // lui $3 (Tnew 0) in E, beq reading $3 at Tuse 0
    task automatic test_e_forward();
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd3, 1'b1, 2'd0);
        tick();
        set_d(5'd3, 5'd0, 2'd0, 2'd0, 5'd0, 1'b0, 2'd0);
        @(negedge clk);
        n_tests++;
        if (stall !== 1'b0 || D_FwdRs_Sel !== 2'd3) begin
            n_fail++;
            $display("FAIL e_forward_d: got stall=%b dsel=%0d, want 0/3", stall, D_FwdRs_Sel);
        end
        tick();
        idle();
        @(negedge clk);
        n_tests++;
        if (E_FwdRs_Sel !== 2'd2) begin
            n_fail++;
            $display("FAIL e_forward_m: got esel=%0d, want 2", E_FwdRs_Sel);
        end
        drain();
    endtask

    // two adds to $5 (the second also reads $5 on rt), then a reader of $5
    task automatic test_nearest();
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd5, 1'b1, 2'd1);
        tick();
        set_d(5'd0, 5'd5, 2'd3, 2'd1, 5'd5, 1'b1, 2'd1);
        @(negedge clk);
        n_tests++;
        if (stall !== 1'b0 || D_FwdRt_Sel !== 2'd0) begin
            n_fail++;
            $display("FAIL nearest_not_ready: got stall=%b dsel=%0d, want 0/0", stall, D_FwdRt_Sel);
        end
        tick();
        idle();
        @(negedge clk);
        n_tests++;
        if (E_FwdRt_Sel !== 2'd2) begin
            n_fail++;
            $display("FAIL nearest_e_rt: got %0d, want 2", E_FwdRt_Sel);
        end
        tick();
        set_d(5'd5, 5'd0, 2'd1, 2'd3, 5'd0, 1'b0, 2'd0);
        @(negedge clk);
        n_tests++;
        if (D_FwdRs_Sel !== 2'd2 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL nearest_d_rs: got dsel=%0d stall=%b, want 2/0", D_FwdRs_Sel, stall);
        end
        n_tests++;
        if (M_FwdRt_Sel !== 1'b1) begin
            n_fail++;
            $display("FAIL nearest_m_rt: got %b, want 1", M_FwdRt_Sel);
        end
        drain();
    endtask

    task automatic test_reg_zero();
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 1'b1, 2'd2);
        tick();
        set_d(5'd0, 5'd0, 2'd0, 2'd0, 5'd6, 1'b1, 2'd1);
        @(negedge clk);
        n_tests++;
        if ({stall, D_FwdRs_Sel, D_FwdRt_Sel} !== 5'd0) begin
            n_fail++;
            $display("FAIL reg_zero_d: got stall=%b sels=%0d/%0d, want 0", stall, D_FwdRs_Sel, D_FwdRt_Sel);
        end
        tick();
        idle();
        tick();
        @(negedge clk);
        n_tests++;
        if ({E_FwdRs_Sel, E_FwdRt_Sel, M_FwdRt_Sel} !== 5'd0) begin
            n_fail++;
            $display("FAIL reg_zero_em: got %0d/%0d/%b, want 0", E_FwdRs_Sel, E_FwdRt_Sel, M_FwdRt_Sel);
        end
        drain();
    endtask

    // div start with mflo in D: 11 stall cycles, 10 busy cycles
    task automatic test_md_div();
        int n_stall = 0;
        int n_busy  = 0;
        D_MdUse = 1'b1; E_MdStart = 1'b1; E_MdIsDiv = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (stall === 1'b1) n_stall++;
            if (md_busy === 1'b1) n_busy++;
            if (c == 10) begin
                n_tests++;
                if (md_busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL div_busy_c10: got %b, want 1", md_busy);
                end
            end
            tick();
            E_MdStart = 1'b0;
        end
        n_tests++;
        if (n_stall != 11) begin
            n_fail++;
            $display("FAIL div_stall_cycles: got %0d, want 11", n_stall);
        end
        n_tests++;
        if (n_busy != 10) begin
            n_fail++;
            $display("FAIL div_busy_cycles: got %0d, want 10", n_busy);
        end
        drain();
    endtask

    task automatic test_md_reset_abort();
        E_MdStart = 1'b1; E_MdIsDiv = 1'b1;
        tick();
        E_MdStart = 1'b0;
        tick(); tick();
        @(negedge clk);
        n_tests++;
        if (md_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_busy_c3: got %b, want 1", md_busy);
        end
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if (md_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_busy_after_reset: got %b, want 0", md_busy);
        end
        drain();
    endtask

    // div, then mult started 3 cycles later: mult length wins
    task automatic test_md_reload();
        int n_busy = 0;
        E_MdStart = 1'b1; E_MdIsDiv = 1'b1;
        tick();
        E_MdStart = 1'b0;
        tick(); tick();
        E_MdStart = 1'b1; E_MdIsDiv = 1'b0;
        tick();
        E_MdStart = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (md_busy === 1'b1) n_busy++;
            tick();
        end
        n_tests++;
        if (n_busy != 5) begin
            n_fail++;
            $display("FAIL reload_busy_cycles: got %0d, want 5", n_busy);
        end
        drain();
    endtask

    task automatic test_flush();
        flush = 1'b1;
        #1;
        n_tests++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_no_stall: got %b, want 0", stall);
        end
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd2, 1'b1, 2'd2);
        tick();
        flush = 1'b0;
        set_d(5'd2, 5'd0, 2'd0, 2'd3, 5'd0, 1'b0, 2'd0);
        @(negedge clk);
        n_tests++;
        if (stall !== 1'b0 || D_FwdRs_Sel !== 2'd0) begin
            n_fail++;
            $display("FAIL flush_bubble: got stall=%b dsel=%0d, want 0/0", stall, D_FwdRs_Sel);
        end
        drain();
    endtask

    // load-use stall coinciding with flush: one bubble, lw keeps moving
    task automatic test_stall_flush();
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd1, 1'b1, 2'd2);
        tick();
        set_d(5'd1, 5'd0, 2'd0, 2'd3, 5'd0, 1'b0, 2'd0);
        flush = 1'b1;
        @(negedge clk);
        n_tests++;
        if (stall !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_flush_c0: got %b, want 1", stall);
        end
        tick();
        flush = 1'b0;
        tick();
        @(negedge clk);
        n_tests++;
        if (stall !== 1'b0 || D_FwdRs_Sel !== 2'd1) begin
            n_fail++;
            $display("FAIL stall_flush_c2: got stall=%b dsel=%0d, want 0/1", stall, D_FwdRs_Sel);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_e_forward();
        test_nearest();
        test_reg_zero();
        test_md_div();
        test_md_reset_abort();
        test_md_reload();
        test_flush();
        test_stall_flush();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, register-address width.
REQ-002 SHALL have parameter TNEW_W, default 2, width of Tnew/Tuse fields.
REQ-003 SHALL have parameters MULT_CYCLES (default 5) and DIV_CYCLES (default 10), the busy duration of the mult/div unit per operation.
REQ-004 SHALL have ports as follows (one clock; reset synchronous, active-high):
 clk  in  1  clock
 reset  in  1  synchronous active-high reset
 D_Rs, D_Rt  in  ADDR_W  D-stage source registers
 D_Tuse_Rs, D_Tuse_Rt  in  TNEW_W  cycles until D-stage operand is consumed; all-ones means unused
 D_A3  in  ADDR_W  D-stage destination register
 D_RegWrite  in  1  D-stage instruction writes a register
 D_Tnew  in  TNEW_W  cycles, from E entry, until the result exists
 D_MdUse  in  1  D-stage instruction touches mult/div (mult, div, mfhi, mflo, mthi, mtlo)
 E_MdStart  in  1  E-stage instruction starts mult/div this cycle
 E_MdIsDiv  in  1  qualifies E_MdStart: 1 = div, 0 = mult
 flush  in  1  kill the D-stage instruction (insert bubble into E)
 stall  out  1  freeze PC and D; insert bubble into E
 D_FwdRs_Sel, D_FwdRt_Sel  out  2  0 = RF, 1 = W, 2 = M, 3 = E
 E_FwdRs_Sel, E_FwdRt_Sel  out  2  0 = pipeline reg, 1 = W, 2 = M
 M_FwdRt_Sel  out  1  0 = pipeline reg, 1 = W
 md_busy  out  1  mult/div unit is busy

Function
REQ-005 SHALL hold one scoreboard entry per stage E, M, W: valid, A3, Tnew, Rs, Rt.
REQ-006 On each rising clk edge without stall or flush, the D entry SHALL move to E (valid = D_RegWrite && D_A3 != 0); E moves to M; M moves to W; Tnew SHALL decrement by 1 on each move, saturating at 0.
REQ-007 On a stall or flush, E SHALL load a bubble (valid = 0); M and W SHALL still advance.
REQ-008 A stall SHALL be raised combinationally when, for either source src with Tuse != all-ones, the E or M entry is valid, has A3 == src, and has Tnew > Tuse.
REQ-009 A stall SHALL also be raised when D_MdUse && (md_busy || E_MdStart).
REQ-010 The forward select for D_Rs/D_Rt SHALL pick the nearest of E, M, W whose entry is valid, has matching A3, and has Tnew == 0; if none match, it SHALL pick 0.
REQ-011 The E selects SHALL compare the E entry's Rs/Rt against M, then W (Tnew == 0 only). The M select SHALL compare the M entry's Rt against W.
REQ-012 Register 0 SHALL never match; valid entries never carry A3 = 0.
REQ-013 E_MdStart SHALL load the mult/div counter with MULT_CYCLES or DIV_CYCLES.
REQ-014 The counter SHALL decrement each cycle while non-zero; md_busy = (counter != 0).
REQ-015 E_MdStart while md_busy SHALL reload the counter; the latest start wins.
REQ-016 When stall and flush coincide, the bubble SHALL be inserted exactly once; flush alone SHALL NOT assert stall.
REQ-017 All outputs SHALL be combinational functions of registered state and current inputs; there SHALL be no output latency beyond that.

Reset
REQ-018 On reset, all entry valid bits and the mult/div counter SHALL clear to 0.
REQ-019 During and immediately after reset, stall = 0 unless the md condition (E_MdStart) applies, all select outputs = 0, and md_busy = 0.
REQ-020 Reset asserted mid mult/div SHALL abort the operation: the counter reads 0 in the next cycle.

Structure
REQ-021 The forward-select encodings (RF/W/M/E), the Tuse "unused" value, and the entry record type SHALL live in shared package hazard_pkg.
REQ-022 The mult/div busy counter SHALL be a sub-module, md_busy_counter.
REQ-023 The stall/forward comparison SHALL be written once as a function in hazard_pkg and reused.

Verification
REQ-024 lw $1 in D (Tnew 2), next add uses $1 with Tuse 1: stall = 1 for exactly 1 cycle; then E_FwdRs_Sel = 1 once lw reaches W.
REQ-025 lui $3 (Tnew 0) in E, beq in D reading $3 with Tuse 0: stall = 0 and D_FwdRs_Sel = 3.
REQ-026 add $5 in both M and W, D reads $5: D_FwdRs_Sel = 2 (nearest stage wins).
REQ-027 Instruction writing $0 followed by a reader of $0: no stall, all selects = 0.
REQ-028 div start (DIV_CYCLES = 10), then mflo in D: stall held for 11 cycles including the start cycle, md_busy falls after 10; reset at cycle 4 clears md_busy the next cycle.
REQ-029 flush while lw $2 is in D: E is a bubble next cycle; a following reader of $2 sees no stall.
